// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake between the boot image source and the instruction-memory loader.
// The source drives valid/data; the loader answers with ready.
interface imem_boot_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader for the MIPS instruction memory: receives a length-prefixed little-endian byte
// image, writes it word by word from address 0, then releases the core and hands over addressing to pc.
module imem_boot_loader #(
    parameter int Nloc  = 32,
    parameter int Abits = $clog2(Nloc)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    imem_boot_loader_if.slave    rx,
    input  logic                 load_req,
    input  logic [29:0]          pc,
    output logic [Abits-1:0]     mem_addr,
    output logic                 mem_we,
    output logic [31:0]          mem_wdata,
    output logic                 cpu_run,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          words_loaded
);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        FLUSH,
        RUN,
        ERR
    } state_t;

    localparam logic [15:0] NLOC16 = 16'(Nloc);

    state_t      state, state_nx;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [23:0] asm_buf;
    logic [31:0] wr_data;
    logic        wr_pend;
    logic        accept;
    logic [15:0] n_full;
    logic        pc_unused;

    assign accept    = rx.rx_valid && rx.rx_ready;
    assign n_full    = {rx.rx_data, count[7:0]};
    assign pc_unused = ^pc[29:Abits];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CNT_LO;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            CNT_LO: if (accept) state_nx = CNT_HI;
            CNT_HI: begin
                if (accept) begin
                    if (n_full == 16'd0)        state_nx = RUN;
                    else if (n_full > NLOC16)   state_nx = ERR;
                    else                        state_nx = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3 && word_idx == count - 16'd1)
                    state_nx = FLUSH;
            end
            FLUSH:    state_nx = RUN;
            RUN, ERR: if (load_req) state_nx = CNT_LO;
            default:  state_nx = CNT_LO;
        endcase
    end

    // The write of a completed word overlaps reception of the next word's bytes;
    // the last word's write happens in FLUSH through the same pending flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            asm_buf      <= '0;
            wr_data      <= '0;
            wr_pend      <= 1'b0;
        end else begin
            if (wr_pend) begin
                wr_pend      <= 1'b0;
                word_idx     <= word_idx + 16'd1;
                words_loaded <= words_loaded + 16'd1;
            end
            case (state)
                CNT_LO: if (accept) count[7:0] <= rx.rx_data;
                CNT_HI: begin
                    if (accept) begin
                        count[15:8] <= rx.rx_data;
                        byte_idx    <= '0;
                        word_idx    <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_data <= {rx.rx_data, asm_buf};
                            wr_pend <= 1'b1;
                        end else begin
                            asm_buf <= {rx.rx_data, asm_buf[23:8]};
                        end
                    end
                end
                RUN, ERR: begin
                    if (load_req) begin
                        words_loaded <= '0;
                        word_idx     <= '0;
                        byte_idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rx.rx_ready = (state == CNT_LO) || (state == CNT_HI) || (state == DATA);
        cpu_run     = (state == RUN);
        done        = (state == RUN);
        err         = (state == ERR);
        mem_we      = wr_pend;
        mem_wdata   = wr_data;
        mem_addr    = (state == RUN) ? pc[Abits-1:0] : word_idx[Abits-1:0];
    end

endmodule
